uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (1 start, 8 data LSB first, 1 stop), CLKS_PER_BIT clocks per bit.
// Define UART_RX_PARITY_EN to insert one even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_meta;
    logic             rxs;
    logic             rxs_prev;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign busy = (state != IDLE);

    // Receive FSM; status pulses default low every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rd_ack) begin
                valid <= 1'b0;
            end

            if (!ena) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= '0;
`ifdef UART_RX_PARITY_EN
                par_bad <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A held-low line (break) never shows a 1->0 transition, so it cannot restart us.
                        if (rxs_prev && !rxs) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt == CNT_HALF) begin
                            cnt   <= '0;
                            state <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_FULL) begin
                            cnt            <= '0;
                            shreg[bit_idx] <= rxs;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == CNT_FULL) begin
                            cnt     <= '0;
                            par_bad <= (rxs != (^shreg));
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == CNT_FULL) begin
                            cnt   <= '0;
                            state <= IDLE;
                            if (!rxs) begin
                                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                data    <= shreg;
                                valid   <= 1'b1;
                                overrun <= valid && !rd_ack;
                            end
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT=16); table vectors, corner sequences, random frames.
// Build both files with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;
    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Offset (in clocks from the first start-bit drive) where a completed frame becomes visible.
    localparam int COMPL     = 2 + int'(CPB) / 2 + int'(CPB) * (NBITS - 1) + 1;
    localparam int FRAME_LEN = int'(CPB) * NBITS + 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx        (rx),
        .rd_ack    (rd_ack),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       v_before;
        logic       b_pre;
        logic       b_start;
        logic       b_last;
        logic       b_end;
        logic       b_abort;
        logic       fe_at;
        int         fe_cnt;
        int         pe_cnt;
        int         ov_cnt;
        int         busy_late;
    } res_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       pre;
        logic       comp;
        int         hold;
        logic [7:0] exp_d;
        logic       exp_v;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line level for clock n of a frame driven from the bit-level framing rules.
    function automatic logic line_level(input int n, input logic [7:0] b, input logic stop,
                                        input logic par_ok, input int hold_low, input int abort_n);
        int k;
        k = n / int'(CPB);
        if (abort_n > 0 && n >= abort_n) return 1'b1;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (k == NBITS - 1) return stop;
        if (k < NBITS - 1) return (^b) ^ ~par_ok;
        if (!stop && n < int'(CPB) * NBITS + hold_low) return 1'b0;
        return 1'b1;
    endfunction

    // abort_kind: 0 = drop ena for one clock, 1 = pulse rst_n for one clock.
    task automatic run_frame(input logic [7:0] b, input logic stop, input logic par_ok,
                             input logic pre_ack, input logic comp_ack, input int hold_low,
                             input int abort_n, input int abort_kind, output res_t r);
        r.d = '0; r.v = 1'b0; r.v_before = 1'b0; r.b_pre = 1'b0; r.b_start = 1'b0;
        r.b_last = 1'b0; r.b_end = 1'b0; r.b_abort = 1'b0; r.fe_at = 1'b0;
        r.fe_cnt = 0; r.pe_cnt = 0; r.ov_cnt = 0; r.busy_late = 0;
        for (int n = 0; n < FRAME_LEN + hold_low; n++) begin
            @(posedge clk);
            #1;
            rx     = line_level(n, b, stop, par_ok, hold_low, abort_n);
            rd_ack = (pre_ack && n == 0) || (comp_ack && n == COMPL - 1);
            ena    = !(abort_n > 0 && n == abort_n && abort_kind == 0);
            rst_n  = !(abort_n > 0 && n == abort_n && abort_kind == 1);
            @(negedge clk);
            if (frame_err)  r.fe_cnt++;
            if (parity_err) r.pe_cnt++;
            if (overrun)    r.ov_cnt++;
            if (n == 2) r.b_pre = busy;
            if (n == 3) r.b_start = busy;
            if (n == COMPL - 1) begin
                r.b_last   = busy;
                r.v_before = valid;
            end
            if (n == COMPL) begin
                r.b_end = busy;
                r.d     = data;
                r.v     = valid;
                r.fe_at = frame_err;
            end
            if (n >= COMPL && busy) r.busy_late++;
            if (abort_n > 0 && n == abort_n + 1) r.b_abort = busy;
        end
        rd_ack = 1'b0;
        ena    = 1'b1;
        rst_n  = 1'b1;
    endtask

    vec_t       vecs[8];
    res_t       r;
    logic [7:0] m_data;
    logic       m_valid;
    logic [7:0] rb;
    logic       rstop, rpar, rpre, rcomp, exp_vb, exp_ov;
    int         g_fe, g_pe, g_ov;
    logic       g_b10, g_b11, g_b3;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0,  8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 64, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 0,  8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 0,  8'h22, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h33, 1'b1, 1'b0, 1'b1, 0,  8'h33, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h44, 1'b0, 1'b1, 1'b0, 0,  8'h33, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 0,  8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 0,  8'hFF, 1'b1, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].b, vecs[i].stop, 1'b1, vecs[i].pre, vecs[i].comp, vecs[i].hold, 0, 0, r);
            check($sformatf("v%0d_data", i), 32'(r.d), 32'(vecs[i].exp_d));
            check($sformatf("v%0d_valid", i), 32'(r.v), 32'(vecs[i].exp_v));
            check($sformatf("v%0d_fe_cnt", i), 32'(r.fe_cnt), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_fe_at", i), 32'(r.fe_at), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_ov_cnt", i), 32'(r.ov_cnt), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_pe_cnt", i), 32'(r.pe_cnt), 32'd0);
            check($sformatf("v%0d_busy_pre", i), 32'(r.b_pre), 32'd0);
            check($sformatf("v%0d_busy_start", i), 32'(r.b_start), 32'd1);
            check($sformatf("v%0d_busy_last", i), 32'(r.b_last), 32'd1);
            check($sformatf("v%0d_busy_end", i), 32'(r.b_end), 32'd0);
            check($sformatf("v%0d_busy_late", i), 32'(r.busy_late), 32'd0);
        end

        // Start glitch: line low for 5 clocks only.
        g_fe = 0; g_pe = 0; g_ov = 0; g_b3 = 1'b0; g_b10 = 1'b0; g_b11 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1 rx = (n >= 5);
            @(negedge clk);
            if (frame_err)  g_fe++;
            if (parity_err) g_pe++;
            if (overrun)    g_ov++;
            if (n == 3)  g_b3 = busy;
            if (n == 10) g_b10 = busy;
            if (n == 11) g_b11 = busy;
        end
        check("glitch_busy_start", 32'(g_b3), 32'd1);
        check("glitch_busy_sample", 32'(g_b10), 32'd1);
        check("glitch_busy_abort", 32'(g_b11), 32'd0);
        check("glitch_flags", 32'(g_fe + g_pe + g_ov), 32'd0);
        check("glitch_data", 32'(data), 32'hFF);
        check("glitch_valid", 32'(valid), 32'd1);

        // ena dropped during data bit 4 of 0x55, then a clean 0x0F.
        run_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 0, int'(CPB) * 5 + 8, 0, r);
        check("ena_abort_busy", 32'(r.b_abort), 32'd0);
        check("ena_abort_data", 32'(r.d), 32'hFF);
        check("ena_abort_valid", 32'(r.v), 32'd1);
        check("ena_abort_flags", 32'(r.fe_cnt + r.pe_cnt + r.ov_cnt), 32'd0);
        check("ena_abort_late", 32'(r.busy_late), 32'd0);
        run_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, r);
        check("ena_next_data", 32'(r.d), 32'h0F);
        check("ena_next_valid", 32'(r.v), 32'd1);
        check("ena_next_ov", 32'(r.ov_cnt), 32'd0);

        // Reset pulsed during data bit 4 of 0x55, then a clean 0x0F.
        run_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 0, int'(CPB) * 5 + 8, 1, r);
        check("rst_abort_busy", 32'(r.b_abort), 32'd0);
        check("rst_abort_data", 32'(r.d), 32'h00);
        check("rst_abort_valid", 32'(r.v), 32'd0);
        check("rst_abort_flags", 32'(r.fe_cnt + r.pe_cnt + r.ov_cnt), 32'd0);
        check("rst_abort_late", 32'(r.busy_late), 32'd0);
        run_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, r);
        check("rst_next_data", 32'(r.d), 32'h0F);
        check("rst_next_valid", 32'(r.v), 32'd1);
        check("rst_next_ov", 32'(r.ov_cnt), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 carries odd data weight, so the even-parity bit is 1.
        run_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, r);
        check("par_bad_pe", 32'(r.pe_cnt), 32'd1);
        check("par_bad_fe", 32'(r.fe_cnt), 32'd0);
        check("par_bad_data", 32'(r.d), 32'h0F);
        check("par_bad_valid", 32'(r.v), 32'd0);
        run_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, r);
        check("par_ok_pe", 32'(r.pe_cnt), 32'd0);
        check("par_ok_data", 32'(r.d), 32'h07);
        check("par_ok_valid", 32'(r.v), 32'd1);
`endif

        // Random frames against a frame-level model.
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rand_rst_data", 32'(data), 32'h00);
        check("rand_rst_valid", 32'(valid), 32'd0);
        m_data  = 8'h00;
        m_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            rpar  = ($urandom_range(0, 4) != 0);
`else
            rpar  = 1'b1;
`endif
            rpre  = ($urandom_range(0, 2) == 0);
            rcomp = ($urandom_range(0, 3) == 0);
            if (rpre) m_valid = 1'b0;
            exp_vb = m_valid;
            exp_ov = 1'b0;
            if (rstop && rpar) begin
                exp_ov  = m_valid && !rcomp;
                m_data  = rb;
                m_valid = 1'b1;
            end else if (rcomp) begin
                m_valid = 1'b0;
            end
            run_frame(rb, rstop, rpar, rpre, rcomp, 0, 0, 0, r);
            check($sformatf("r%0d_data", i), 32'(r.d), 32'(m_data));
            check($sformatf("r%0d_valid", i), 32'(r.v), 32'(m_valid));
            check($sformatf("r%0d_valid_before", i), 32'(r.v_before), 32'(exp_vb));
            check($sformatf("r%0d_fe_cnt", i), 32'(r.fe_cnt), 32'(!rstop));
            check($sformatf("r%0d_pe_cnt", i), 32'(r.pe_cnt), 32'(rstop && !rpar));
            check($sformatf("r%0d_ov_cnt", i), 32'(r.ov_cnt), 32'(exp_ov));
            check($sformatf("r%0d_busy_end", i), 32'(r.b_end), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
